// File: rtl/bram_rd_streamer.sv
// Request front end for a multi-bank BRAM mux: drives the fixed-latency BRAM port and
// returns read data in order through a credit-protected show-ahead response FIFO.
module bram_rd_streamer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 512,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_wr,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [DATA_WIDTH-1:0]              req_wr_data,
    output logic [ADDR_WIDTH-1:0]              bram_addr,
    output logic [DATA_WIDTH-1:0]              bram_wr_data,
    output logic                               bram_rd_en,
    output logic                               bram_wr_en,
    input  logic [DATA_WIDTH-1:0]              bram_rd_data,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    credits,
    output logic                               overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    logic [CW-1:0]         credits_q, credits_d;
    logic                  req_ready_q, req_ready_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_wr_data_q, bram_wr_data_d;
    logic                  bram_rd_en_q, bram_rd_en_d;
    logic                  bram_wr_en_q, bram_wr_en_d;
    logic [RD_LATENCY:0]   trk_q, trk_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic accept_s, rd_accept_s, pop_s, push_s, full_s, fifo_we_s, head_is_new_s;

    // Handshake decode and credit accounting; a credit is held from read accept until pop.
    always_comb begin
        accept_s    = req_valid & req_ready_q;
        rd_accept_s = accept_s & ~req_wr;
        pop_s       = rsp_valid_q & rsp_ready;
        credits_d   = credits_q;
        case ({rd_accept_s, pop_s})
            2'b10:   credits_d = (credits_q != '0) ? credits_q - CW'(1) : credits_q;
            2'b01:   credits_d = (credits_q != CRED_MAX) ? credits_q + CW'(1) : credits_q;
            default: credits_d = credits_q;
        endcase
        req_ready_d = (credits_d != '0);
    end

    // BRAM port registers: strobes last one cycle, address/data hold between accepts.
    always_comb begin
        bram_addr_d    = bram_addr_q;
        bram_wr_data_d = bram_wr_data_q;
        bram_rd_en_d   = 1'b0;
        bram_wr_en_d   = 1'b0;
        if (accept_s) begin
            bram_addr_d    = req_addr;
            bram_wr_data_d = req_wr_data;
            bram_rd_en_d   = ~req_wr;
            bram_wr_en_d   = req_wr;
        end else begin
            bram_rd_en_d   = 1'b0;
            bram_wr_en_d   = 1'b0;
        end
        trk_d = {trk_q[RD_LATENCY-1:0], bram_rd_en_q};
    end

    // Response FIFO bookkeeping; rsp_data is registered so the head must be precomputed.
    always_comb begin
        push_s        = trk_q[RD_LATENCY];
        full_s        = (count_q == CNT_FULL);
        fifo_we_s     = push_s & (~full_s | pop_s);
        wr_ptr_d      = fifo_we_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        case ({fifo_we_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        head_is_new_s = fifo_we_s & (pop_s ? (count_q == (AW+1)'(1)) : (count_q == '0));
        rsp_valid_d   = (count_d != '0);
        if (count_d == '0) begin
            rsp_data_d = rsp_data_q;
        end else if (head_is_new_s) begin
            rsp_data_d = bram_rd_data;
        end else begin
            rsp_data_d = fifo_mem[rd_ptr_d];
        end
        overflow_d = overflow_q | (push_s & full_s & ~pop_s);
    end

    // State registers; reset also clears the tracker so late mux data is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q      <= CRED_MAX;
            req_ready_q    <= 1'b1;
            bram_addr_q    <= '0;
            bram_wr_data_q <= '0;
            bram_rd_en_q   <= 1'b0;
            bram_wr_en_q   <= 1'b0;
            trk_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            credits_q      <= credits_d;
            req_ready_q    <= req_ready_d;
            bram_addr_q    <= bram_addr_d;
            bram_wr_data_q <= bram_wr_data_d;
            bram_rd_en_q   <= bram_rd_en_d;
            bram_wr_en_q   <= bram_wr_en_d;
            trk_q          <= trk_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage write port; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (fifo_we_s) begin
            fifo_mem[wr_ptr_q] <= bram_rd_data;
        end
    end

    assign req_ready    = req_ready_q;
    assign credits      = credits_q;
    assign bram_addr    = bram_addr_q;
    assign bram_wr_data = bram_wr_data_q;
    assign bram_rd_en   = bram_rd_en_q;
    assign bram_wr_en   = bram_wr_en_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Bench for bram_rd_streamer: fixed-latency BRAM model, table vectors, corner sequences
// and a randomized run against a reference memory and expected-response queue.
module tb_bram_rd_streamer;

    localparam int AWD = 16;
    localparam int DW  = 512;
    localparam int L   = 3;
    localparam int FD  = 8;
    localparam int CW  = $clog2(FD + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [AWD-1:0] req_addr = '0;
    logic [DW-1:0]  req_wr_data = '0;
    logic           req_ready, bram_rd_en, bram_wr_en, rsp_valid, overflow;
    logic [AWD-1:0] bram_addr;
    logic [DW-1:0]  bram_wr_data, bram_rd_data, rsp_data;
    logic [CW-1:0]  credits;

    int n_checks = 0;
    int n_errors = 0;
    int outstanding = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [0:255];

    bram_rd_streamer #(.ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .RD_LATENCY(L), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wr_data(req_wr_data),
        .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .bram_rd_en(bram_rd_en),
        .bram_wr_en(bram_wr_en), .bram_rd_data(bram_rd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .credits(credits), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        logic [DW-1:0] v;
        if (a == 4) v = 512'hA5;
        else        v = {16{32'h5A00_0000 | a}};
        return v;
    endfunction

    // BRAM mux model: data sampled at the rd_en edge appears L edges later.
    logic [DW-1:0] mux_mem [0:255];
    logic          mux_wflag [0:255];
    logic [DW-1:0] pipe [0:L];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 256; k++) mux_wflag[k] <= 1'b0;
        end else if (bram_wr_en) begin
            mux_mem[bram_addr[7:0]]   <= bram_wr_data;
            mux_wflag[bram_addr[7:0]] <= 1'b1;
        end
        pipe[0] <= bram_rd_en ? (mux_wflag[bram_addr[7:0]] ? mux_mem[bram_addr[7:0]]
                                                           : init_val(int'(bram_addr[7:0])))
                              : {16{32'hDEAD_BEEF}};
        for (int k = 1; k <= L; k++) pipe[k] <= pipe[k-1];
    end
    assign bram_rd_data = pipe[L];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input int a);
        req_valid   = v;
        req_wr      = wr;
        req_addr    = AWD'(a);
        req_wr_data = '0;
    endtask

    // One randomized (or draining) cycle with scoreboard update.
    task automatic rnd_step(input bit active, input int c);
        logic acc, pp;
        logic [DW-1:0] e;
        if (active) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_wr      = ($urandom_range(0, 2) == 0);
            req_addr    = AWD'(64 + $urandom_range(0, 15));
            req_wr_data = {16{$urandom}};
            rsp_ready   = ($urandom_range(0, 99) < (((c / 500) % 2) != 0 ? 20 : 90));
        end else begin
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        acc = req_valid && req_ready;
        pp  = rsp_valid && rsp_ready;
        if (pp) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rnd_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                e = exp_q.pop_front();
                chk("rnd_data", rsp_data, e);
            end
        end
        if (acc) begin
            if (req_wr) begin
                ref_mem[req_addr[7:0]] = req_wr_data;
            end else begin
                exp_q.push_back(ref_mem[req_addr[7:0]]);
                outstanding++;
            end
        end
        if (pp) outstanding--;
        tick();
        chk("rnd_credits", DW'(credits), DW'(FD - outstanding));
    endtask

    typedef struct {
        logic          v, wr;
        logic [15:0]   a;
        logic [DW-1:0] d;
        logic          rr;
        logic          e_ready, e_rd, e_wr;
        logic [15:0]   e_addr;
        int            e_cred;
        logic          e_rv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vt [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1'b1, 16'h2, 512'h11, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2, 8, 1'b0, 512'h0};
        vt[1] = '{1'b1, 1'b0, 16'h2, 512'h0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h2, 7, 1'b0, 512'h0};
        vt[2] = '{1'b1, 1'b1, 16'h2, 512'h22, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2, 7, 1'b0, 512'h0};
        vt[3] = '{1'b1, 1'b0, 16'h2, 512'h0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h2, 6, 1'b0, 512'h0};
        vt[4] = '{1'b0, 1'b0, 16'h0, 512'h0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h2, 6, 1'b0, 512'h0};
        vt[5] = '{1'b0, 1'b0, 16'h0, 512'h0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h2, 6, 1'b0, 512'h0};
        vt[6] = '{1'b0, 1'b0, 16'h0, 512'h0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h2, 6, 1'b1, 512'h11};
        vt[7] = '{1'b0, 1'b0, 16'h0, 512'h0,  1'b1, 1'b1, 1'b0, 1'b0, 16'h2, 7, 1'b0, 512'h0};
        vt[8] = '{1'b0, 1'b0, 16'h0, 512'h0,  1'b1, 1'b1, 1'b0, 1'b0, 16'h2, 7, 1'b1, 512'h22};
        vt[9] = '{1'b0, 1'b0, 16'h0, 512'h0,  1'b1, 1'b1, 1'b0, 1'b0, 16'h2, 8, 1'b0, 512'h0};

        // Reset values
        tick();
        tick();
        chk("rst_req_ready", DW'(req_ready), DW'(1));
        chk("rst_credits", DW'(credits), DW'(FD));
        chk("rst_rd_en", DW'(bram_rd_en), DW'(0));
        chk("rst_wr_en", DW'(bram_wr_en), DW'(0));
        chk("rst_addr", DW'(bram_addr), DW'(0));
        chk("rst_wr_data", bram_wr_data, DW'(0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_rsp_data", rsp_data, DW'(0));
        chk("rst_overflow", DW'(overflow), DW'(0));
        rst_n = 1'b1;

        // Mixed write/read table
        for (int i = 0; i < 10; i++) begin
            req_valid = vt[i].v; req_wr = vt[i].wr; req_addr = vt[i].a;
            req_wr_data = vt[i].d; rsp_ready = vt[i].rr;
            tick();
            chk($sformatf("tbl%0d_ready", i), DW'(req_ready), DW'(vt[i].e_ready));
            chk($sformatf("tbl%0d_rd_en", i), DW'(bram_rd_en), DW'(vt[i].e_rd));
            chk($sformatf("tbl%0d_wr_en", i), DW'(bram_wr_en), DW'(vt[i].e_wr));
            chk($sformatf("tbl%0d_addr", i), DW'(bram_addr), DW'(vt[i].e_addr));
            chk($sformatf("tbl%0d_credits", i), DW'(credits), DW'(vt[i].e_cred));
            chk($sformatf("tbl%0d_rsp_valid", i), DW'(rsp_valid), DW'(vt[i].e_rv));
            if (vt[i].e_rv) chk($sformatf("tbl%0d_rsp_data", i), rsp_data, vt[i].e_rdata);
            if (vt[i].e_wr) chk($sformatf("tbl%0d_wr_data", i), bram_wr_data, vt[i].d);
        end
        rsp_ready = 1'b0;

        // Single read latency: accept edge T, response visible after T+L+2
        drive(1'b1, 1'b0, 4);
        tick();
        drive(1'b0, 1'b0, 0);
        chk("single_rd_en", DW'(bram_rd_en), DW'(1));
        chk("single_addr", DW'(bram_addr), DW'(4));
        chk("single_credits", DW'(credits), DW'(FD - 1));
        for (int k = 1; k <= L + 1; k++) begin
            tick();
            chk($sformatf("single_early_valid_%0d", k), DW'(rsp_valid), DW'(0));
        end
        tick();
        chk("single_valid", DW'(rsp_valid), DW'(1));
        chk("single_data", rsp_data, DW'(512'hA5));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_credits_after_pop", DW'(credits), DW'(FD));
        chk("single_valid_after_pop", DW'(rsp_valid), DW'(0));

        // Back-to-back reads fill all credits
        for (int i = 0; i < FD; i++) begin
            drive(1'b1, 1'b0, 10 + i);
            tick();
        end
        chk("b2b_ready_low", DW'(req_ready), DW'(0));
        chk("b2b_credits_zero", DW'(credits), DW'(0));
        drive(1'b1, 1'b0, 99);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("b2b_no_accept", DW'(bram_rd_en), DW'(0));
        end
        drive(1'b0, 1'b0, 0);
        tick();
        for (int i = 0; i < FD; i++) begin
            chk($sformatf("b2b_valid_%0d", i), DW'(rsp_valid), DW'(1));
            chk($sformatf("b2b_data_%0d", i), rsp_data, init_val(10 + i));
            rsp_ready = 1'b1;
            tick();
            if (i == 0) begin
                chk("b2b_credits_first_pop", DW'(credits), DW'(1));
                chk("b2b_ready_first_pop", DW'(req_ready), DW'(1));
            end
        end
        rsp_ready = 1'b0;
        chk("b2b_drained", DW'(rsp_valid), DW'(0));
        chk("b2b_credits_full", DW'(credits), DW'(FD));
        chk("b2b_overflow", DW'(overflow), DW'(0));

        // Simultaneous accept and pop with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 20 + i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("sim_credits_before", DW'(credits), DW'(FD - 3));
        chk("sim_head", rsp_data, init_val(20));
        drive(1'b1, 1'b0, 23);
        rsp_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 0);
        chk("sim_credits_same", DW'(credits), DW'(FD - 3));
        chk("sim_rd_en", DW'(bram_rd_en), DW'(1));
        chk("sim_next_head", rsp_data, init_val(21));
        for (int k = 0; k < 10; k++) tick();
        rsp_ready = 1'b0;
        chk("sim_credits_after", DW'(credits), DW'(FD));

        // Reset with reads in flight
        drive(1'b1, 1'b0, 30);
        tick();
        drive(1'b1, 1'b0, 31);
        tick();
        drive(1'b0, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rmf_valid", DW'(rsp_valid), DW'(0));
        chk("rmf_credits", DW'(credits), DW'(FD));
        chk("rmf_ready", DW'(req_ready), DW'(1));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rmf_no_late_push_%0d", k), DW'(rsp_valid), DW'(0));
        end
        chk("rmf_credits_late", DW'(credits), DW'(FD));

        // Random traffic against the reference memory
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        for (int c = 0; c < 10000; c++) rnd_step(1'b1, c);
        for (int g = 0; g < 60 && outstanding != 0; g++) rnd_step(1'b0, 0);
        drive(1'b0, 1'b0, 0);
        rsp_ready = 1'b0;
        chk("rnd_drained", DW'(outstanding), DW'(0));
        chk("rnd_overflow", DW'(overflow), DW'(0));
        chk("rnd_credits_final", DW'(credits), DW'(FD));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
